// File: rtl/canny_sram_reader.sv
// Reads interleaved top/bottom row-pair words from SRAM and unpacks them into
// 4-byte beats (2 bottom-row + 2 top-row pixels) for the downstream stream.
module canny_sram_reader #(
    parameter int unsigned STARTADDRESS = 0,
    parameter int unsigned ENDADDRESS   = 131072,
    parameter int unsigned ROWBITS      = 8,
    parameter int unsigned RDLAT        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        re,
    output logic [19:0] rdaddr,
    input  logic [63:0] rdData,
    output logic        pixValid,
    input  logic        pixReady,
    output logic [7:0]  pixByte1,
    output logic [7:0]  pixByte2,
    output logic [7:0]  pixByte3,
    output logic [7:0]  pixByte4,
    output logic        busy,
    output logic        frameDone,
    output logic [2:0]  dbgState
);

    // Handshake: a beat transfers on a rising clk edge where pixValid && pixReady;
    // while pixValid=1 and pixReady=0 the beat bytes are held unchanged.

    localparam int unsigned ROWWORDS = 1 << ROWBITS;
    localparam logic [19:0] START_A  = 20'(STARTADDRESS);
    localparam logic [19:0] ROW_A    = 20'(ROWWORDS);
    localparam logic [20:0] END_A    = 21'(ENDADDRESS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_TOP = 3'd1,
        RD_BOT = 3'd2,
        WAIT   = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    logic [19:0] currentAddress;
    logic [1:0]  beat;
    logic        rdIsBot;
    logic [63:0] topHold;
    logic [63:0] botHold;
    logic        topGot;
    logic        botGot;
    logic [RDLAT-1:0] tagValid;
    logic [RDLAT-1:0] tagBot;
    logic [20:0] nextAddress;
    logic [31:0] nextBeatBytes;

    assign dbgState = state;

    // Returns {bot even, bot odd, top even, top odd} for beat k (k=0 is bits 63:48).
    function automatic logic [31:0] beatBytes(input logic [63:0] top,
                                              input logic [63:0] bot,
                                              input logic [1:0]  k);
        logic [63:0] t;
        logic [63:0] b;
        int          sh;
        sh = 48 - 16 * int'(k);
        t  = top >> sh;
        b  = bot >> sh;
        return {b[15:8], b[7:0], t[15:8], t[7:0]};
    endfunction

    // At the end of a row the bottom row has already been read as part of the
    // pair, so the next pair starts one full row further on.
    always_comb begin
        nextAddress = 21'd0;
        if (currentAddress[ROWBITS-1:0] == {ROWBITS{1'b1}})
            nextAddress = {1'b0, currentAddress} + {1'b0, ROW_A} + 21'd1;
        else
            nextAddress = {1'b0, currentAddress} + 21'd1;
    end

    always_comb begin
        nextBeatBytes = beatBytes(topHold, botHold, beat + 2'd1);
    end

    // Read tags travel with each SRAM access so returning data lands in the
    // right hold register regardless of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            tagValid <= '0;
            tagBot   <= '0;
        end else begin
            tagValid[0] <= re;
            tagBot[0]   <= rdIsBot;
            for (int i = 1; i < int'(RDLAT); i++) begin
                tagValid[i] <= tagValid[i-1];
                tagBot[i]   <= tagBot[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            re             <= 1'b0;
            rdaddr         <= 20'd0;
            rdIsBot        <= 1'b0;
            pixValid       <= 1'b0;
            pixByte1       <= 8'd0;
            pixByte2       <= 8'd0;
            pixByte3       <= 8'd0;
            pixByte4       <= 8'd0;
            busy           <= 1'b0;
            frameDone      <= 1'b0;
            currentAddress <= START_A;
            beat           <= 2'd0;
            topHold        <= 64'd0;
            botHold        <= 64'd0;
            topGot         <= 1'b0;
            botGot         <= 1'b0;
        end else begin
            re        <= 1'b0;
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        currentAddress <= START_A;
                        re             <= 1'b1;
                        rdaddr         <= START_A;
                        rdIsBot        <= 1'b0;
                        topGot         <= 1'b0;
                        botGot         <= 1'b0;
                        state          <= RD_TOP;
                    end
                end
                RD_TOP: begin
                    re      <= 1'b1;
                    rdaddr  <= currentAddress + ROW_A;
                    rdIsBot <= 1'b1;
                    state   <= RD_BOT;
                end
                RD_BOT: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (topGot && botGot) begin
                        beat     <= 2'd0;
                        pixValid <= 1'b1;
                        {pixByte1, pixByte2, pixByte3, pixByte4} <=
                            beatBytes(topHold, botHold, 2'd0);
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pixReady) begin
                        if (beat == 2'd3) begin
                            pixValid       <= 1'b0;
                            currentAddress <= nextAddress[19:0];
                            if (nextAddress >= END_A) begin
                                frameDone <= 1'b1;
                                busy      <= 1'b0;
                                state     <= DONE;
                            end else begin
                                re      <= 1'b1;
                                rdaddr  <= nextAddress[19:0];
                                rdIsBot <= 1'b0;
                                topGot  <= 1'b0;
                                botGot  <= 1'b0;
                                state   <= RD_TOP;
                            end
                        end else begin
                            beat <= beat + 2'd1;
                            {pixByte1, pixByte2, pixByte3, pixByte4} <= nextBeatBytes;
                        end
                    end
                end
                DONE: begin
                    pixValid <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (tagValid[RDLAT-1]) begin
                if (tagBot[RDLAT-1]) begin
                    botHold <= rdData;
                    botGot  <= 1'b1;
                end else begin
                    topHold <= rdData;
                    topGot  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_canny_sram_reader.sv
// Bench for canny_sram_reader: SRAM model with RDLAT latency, scoreboard of
// expected read addresses and beats, table check of one unpacked pair.
module tb_canny_sram_reader;

    localparam int unsigned START  = 0;
    localparam int unsigned ENDA   = 514;
    localparam int unsigned RDLAT  = 3;
    localparam logic [2:0]  IDLE_S = 3'd0;
    localparam logic [2:0]  WAIT_S = 3'd3;

    logic        clk;
    logic        reset;
    logic        start;
    logic        re;
    logic [19:0] rdaddr;
    logic [63:0] rdData;
    logic        pixValid;
    logic        pixReady;
    logic [7:0]  pixByte1;
    logic [7:0]  pixByte2;
    logic [7:0]  pixByte3;
    logic [7:0]  pixByte4;
    logic        busy;
    logic        frameDone;
    logic [2:0]  dbgState;

    canny_sram_reader #(
        .STARTADDRESS(START),
        .ENDADDRESS  (ENDA),
        .ROWBITS     (8),
        .RDLAT       (RDLAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .re       (re),
        .rdaddr   (rdaddr),
        .rdData   (rdData),
        .pixValid (pixValid),
        .pixReady (pixReady),
        .pixByte1 (pixByte1),
        .pixByte2 (pixByte2),
        .pixByte3 (pixByte3),
        .pixByte4 (pixByte4),
        .busy     (busy),
        .frameDone(frameDone),
        .dbgState (dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;
    int doneCnt = 0;
    bit monOn = 0;
    logic [19:0] expAddrQ[$];
    logic [31:0] expBeatQ[$];
    logic [19:0] addrLog[$];
    logic [31:0] beatLog[$];

    typedef struct {
        int         k;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        logic [7:0] b4;
    } vec_t;
    vec_t tbl[4];

    function automatic logic [63:0] memWord(input logic [19:0] a);
        if (a == 20'd0)   return 64'h0102030405060708;
        if (a == 20'd256) return 64'h1112131415161718;
        return {12'hA5A, a, 12'h5C3, ~a};
    endfunction

    // SRAM model: address sampled with re, data presented RDLAT cycles later.
    logic [19:0] srAddr[RDLAT];
    logic        srV[RDLAT];
    always @(posedge clk) begin
        srV[0]    <= re;
        srAddr[0] <= rdaddr;
        for (int i = 1; i < int'(RDLAT); i++) begin
            srV[i]    <= srV[i-1];
            srAddr[i] <= srAddr[i-1];
        end
    end
    always_comb begin
        rdData = 64'hBAD0BAD0BAD0BAD0;
        if (srV[RDLAT-1] === 1'b1) rdData = memWord(srAddr[RDLAT-1]);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic failNow(input string nm);
        nCmp++;
        nBad++;
        $display("FAIL %s: event missing or unexpected", nm);
    endtask

    task automatic loadFrame();
        logic [19:0] a;
        logic [20:0] nx;
        logic [63:0] top;
        logic [63:0] bot;
        int          hi;
        a = 20'(START);
        do begin
            expAddrQ.push_back(a);
            expAddrQ.push_back(a + 20'd256);
            top = memWord(a);
            bot = memWord(a + 20'd256);
            for (int k = 0; k < 4; k++) begin
                hi = 63 - 16 * k;
                expBeatQ.push_back({bot[hi -: 8], bot[hi-8 -: 8], top[hi -: 8], top[hi-8 -: 8]});
            end
            nx = (a[7:0] == 8'hFF) ? 21'(a) + 21'd257 : 21'(a) + 21'd1;
            a  = nx[19:0];
        end while (nx < 21'(ENDA));
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            if (re) begin
                if (expAddrQ.size() == 0) failNow("rdaddr_extra");
                else check("rdaddr", 64'(rdaddr), 64'(expAddrQ.pop_front()));
                addrLog.push_back(rdaddr);
            end
            if (pixValid && pixReady) begin
                if (expBeatQ.size() == 0) failNow("beat_extra");
                else check("beat", 64'({pixByte1, pixByte2, pixByte3, pixByte4}),
                           64'(expBeatQ.pop_front()));
                beatLog.push_back({pixByte1, pixByte2, pixByte3, pixByte4});
            end
            if (frameDone) doneCnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic pulseStart();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [31:0] held;

        tbl[0] = '{0, 8'h11, 8'h12, 8'h01, 8'h02};
        tbl[1] = '{1, 8'h13, 8'h14, 8'h03, 8'h04};
        tbl[2] = '{2, 8'h15, 8'h16, 8'h05, 8'h06};
        tbl[3] = '{3, 8'h17, 8'h18, 8'h07, 8'h08};

        reset = 1'b1; start = 1'b0; pixReady = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_re", 64'(re), 64'd0);
        check("rst_rdaddr", 64'(rdaddr), 64'd0);
        check("rst_pixValid", 64'(pixValid), 64'd0);
        check("rst_bytes", 64'({pixByte1, pixByte2, pixByte3, pixByte4}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frameDone", 64'(frameDone), 64'd0);
        check("rst_state", 64'(dbgState), 64'(IDLE_S));
        @(posedge clk); #1 reset = 1'b0;

        // First read issued the cycle after start, first beat RDLAT+3 edges later.
        loadFrame();
        monOn = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("start_re", 64'(re), 64'd1);
        check("start_rdaddr", 64'(rdaddr), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        cnt = 0;
        while (!pixValid && cnt < 50) begin @(negedge clk); cnt++; end
        check("first_valid_latency", 64'(cnt), 64'(RDLAT + 3));

        // Stall beat 2 of the first pair.
        cnt = 0;
        while (beatLog.size() < 2 && cnt < 100) begin @(posedge clk); cnt++; end
        if (cnt >= 100) failNow("bp_wait_timeout");
        #1 pixReady = 1'b0;
        @(negedge clk);
        held = {pixByte1, pixByte2, pixByte3, pixByte4};
        check("bp_beat2", 64'(held), 64'({tbl[2].b1, tbl[2].b2, tbl[2].b3, tbl[2].b4}));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("bp_valid", 64'(pixValid), 64'd1);
            check("bp_stable", 64'({pixByte1, pixByte2, pixByte3, pixByte4}), 64'(held));
        end
        @(posedge clk); #1 pixReady = 1'b1;

        cnt = 0;
        while (addrLog.size() < 3 && cnt < 100) begin @(posedge clk); cnt++; end
        if (cnt >= 100) failNow("pair1_timeout");
        check("pair0_beats", 64'(beatLog.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check("unpack_tbl", 64'(beatLog[tbl[i].k]),
                  64'({tbl[i].b1, tbl[i].b2, tbl[i].b3, tbl[i].b4}));

        // A start while busy must not restart the frame.
        pulseStart();

        cnt = 0;
        while (addrLog.size() < 514 && cnt < 6000) begin @(posedge clk); cnt++; end
        if (cnt >= 6000) failNow("wrap_timeout");
        else begin
            check("wrap_top255", 64'(addrLog[510]), 64'd255);
            check("wrap_bot255", 64'(addrLog[511]), 64'd511);
            check("wrap_top512", 64'(addrLog[512]), 64'd512);
            check("wrap_bot512", 64'(addrLog[513]), 64'd768);
        end

        cnt = 0;
        while (!frameDone && cnt < 200) begin @(negedge clk); cnt++; end
        if (cnt >= 200) failNow("done_timeout");
        else begin
            check("done_busy", 64'(busy), 64'd0);
            check("done_pixValid", 64'(pixValid), 64'd0);
            check("done_re", 64'(re), 64'd0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_done_re", 64'(re), 64'd0);
            check("post_done_fd", 64'(frameDone), 64'd0);
        end
        check("done_count", 64'(doneCnt), 64'd1);
        check("addrq_empty", 64'(expAddrQ.size()), 64'd0);
        check("beatq_empty", 64'(expBeatQ.size()), 64'd0);

        // Abort in WAIT, then restart from the frame start.
        addrLog.delete(); beatLog.delete();
        expAddrQ.delete(); expBeatQ.delete();
        expAddrQ.push_back(20'd0); expAddrQ.push_back(20'd256);
        pulseStart();
        cnt = 0;
        while (dbgState != WAIT_S && cnt < 50) begin @(posedge clk); cnt++; end
        if (cnt >= 50) failNow("abort_wait_timeout");
        #1 reset = 1'b1;
        monOn = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_state", 64'(dbgState), 64'(IDLE_S));
        check("abort_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        expAddrQ.delete(); expBeatQ.delete();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("abort_noValid", 64'(pixValid), 64'd0);
            check("abort_noRe", 64'(re), 64'd0);
        end
        loadFrame();
        doneCnt = 0;
        monOn = 1;
        pulseStart();
        cnt = 0;
        while (!frameDone && cnt < 6000) begin @(negedge clk); cnt++; end
        if (cnt >= 6000) failNow("restart_timeout");
        @(negedge clk);
        check("restart_first_addr", 64'(addrLog[0]), 64'd0);
        check("restart_first_beat", 64'(beatLog[0]),
              64'({tbl[0].b1, tbl[0].b2, tbl[0].b3, tbl[0].b4}));
        check("restart_done_count", 64'(doneCnt), 64'd1);
        check("restart_addrq_empty", 64'(expAddrQ.size()), 64'd0);
        check("restart_beatq_empty", 64'(expBeatQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
